disk_loader: RTL and testbench

Block-transfer controller that moves word blocks between the simulated secondary-memory disk and main memory, in either direction. It sits between the processor control unit and the disk. It drives the disk's `addr`/`data`/`tr` pins and accepts the disk's combinational `q`. It also drives the main-memory port, which has a synchronous read. The control unit uses it to load programs from disk at boot or on swap-in, and to write memory pages back to disk on swap-out.

---
 rtl/disk_loader.sv | 171 +++++++++++++++++
 tb/tb_disk_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_loader.sv
// Block-transfer controller moving word blocks between the disk and main memory.
// Optional checksum accumulator is enabled by defining DISK_LOADER_CHECKSUM_EN.
module disk_loader #(
  parameter int DATA_WIDTH      = 16,
  parameter int DISK_ADDR_WIDTH = 15,
  parameter int MEM_ADDR_WIDTH  = 12,
  parameter int LEN_WIDTH       = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dir,
  input  logic [DISK_ADDR_WIDTH-1:0] disk_base,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_base,
  input  logic [LEN_WIDTH-1:0]       len,
  input  logic                       abort,
  output logic [DISK_ADDR_WIDTH-1:0] disk_addr,
  output logic [DATA_WIDTH-1:0]      disk_data,
  output logic                       disk_tr,
  input  logic [DATA_WIDTH-1:0]      disk_q,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_we,
  input  logic [DATA_WIDTH-1:0]      mem_q,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      checksum
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ST_RD,
    ST_WR,
    DONE
  } state_t;

  state_t                     state;
  logic [DISK_ADDR_WIDTH-1:0] disk_cnt;
  logic [MEM_ADDR_WIDTH-1:0]  mem_cnt;
  logic [LEN_WIDTH-1:0]       remaining;
  logic                       busy_r;
  logic                       done_r;
  logic                       last_word;
  logic                       load_wr;
  logic                       store_wr;

  assign last_word = (remaining == LEN_WIDTH'(1));

  // Abort must suppress the write in the very cycle it arrives, so the enables are gated combinationally.
  assign load_wr  = (state == LOAD)  && !abort;
  assign store_wr = (state == ST_WR) && !abort;

  assign disk_addr = disk_cnt;
  assign mem_addr  = mem_cnt;
  assign mem_we    = load_wr;
  assign disk_tr   = store_wr;
  assign mem_data  = (state == LOAD)  ? disk_q : '0;
  assign disk_data = (state == ST_WR) ? mem_q  : '0;
  assign busy      = busy_r;
  assign done      = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      disk_cnt  <= '0;
      mem_cnt   <= '0;
      remaining <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            disk_cnt  <= disk_base;
            mem_cnt   <= mem_base;
            remaining <= len;
            if (len == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= dir ? ST_RD : LOAD;
              busy_r <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (abort) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            disk_cnt  <= disk_cnt + DISK_ADDR_WIDTH'(1);
            mem_cnt   <= mem_cnt + MEM_ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_word) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end

        ST_RD: begin
          if (abort) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            state <= ST_WR;
          end
        end

        // The memory word addressed during ST_RD is on mem_q now and goes straight to the disk.
        ST_WR: begin
          if (abort) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            disk_cnt  <= disk_cnt + DISK_ADDR_WIDTH'(1);
            mem_cnt   <= mem_cnt + MEM_ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_word) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              state <= ST_RD;
            end
          end
        end

        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef DISK_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_r;

  // Running sum of every word actually written; carry out of the top bit is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
    end else if ((state == IDLE) && start) begin
      sum_r <= '0;
    end else if (load_wr) begin
      sum_r <= sum_r + disk_q;
    end else if (store_wr) begin
      sum_r <= sum_r + mem_q;
    end
  end

  assign checksum = sum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_disk_loader.sv
// Randomized self-checking bench for disk_loader: disk/memory models plus a
// transfer-level reference model that predicts every cycle's outputs.
module tb_disk_loader;

  localparam int DW  = 16;
  localparam int DAW = 15;
  localparam int MAW = 12;
  localparam int LW  = 15;

`ifdef DISK_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           dir = 1'b0;
  logic [DAW-1:0] disk_base = '0;
  logic [MAW-1:0] mem_base = '0;
  logic [LW-1:0]  len = '0;
  logic           abort = 1'b0;
  logic [DAW-1:0] disk_addr;
  logic [DW-1:0]  disk_data;
  logic           disk_tr;
  logic [DW-1:0]  disk_q;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_data;
  logic           mem_we;
  logic [DW-1:0]  mem_q = '0;
  logic           busy;
  logic           done;
  logic [DW-1:0]  checksum;

  logic [DW-1:0] tbDisk  [0:32767];
  logic [DW-1:0] tbMem   [0:4095];
  logic [DW-1:0] refDisk [0:32767];
  logic [DW-1:0] refMem  [0:4095];

  typedef struct {
    bit             busy;
    bit             done;
    bit             memWe;
    bit             diskTr;
    bit             chkRd;
    bit             chkSum;
    logic [MAW-1:0] memAddr;
    logic [DAW-1:0] diskAddr;
    logic [DW-1:0]  memData;
    logic [DW-1:0]  diskData;
    logic [DW-1:0]  sum;
  } ExpEntry;

  ExpEntry       expQ[$];
  logic [DW-1:0] idleChk = '0;
  bit            checkEn = 1'b0;
  int            totalChecks = 0;
  int            badChecks = 0;

  disk_loader #(
    .DATA_WIDTH(DW), .DISK_ADDR_WIDTH(DAW), .MEM_ADDR_WIDTH(MAW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
    .disk_base(disk_base), .mem_base(mem_base), .len(len), .abort(abort),
    .disk_addr(disk_addr), .disk_data(disk_data), .disk_tr(disk_tr), .disk_q(disk_q),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  assign disk_q = tbDisk[disk_addr];

  always @(posedge clk) begin
    if (disk_tr) tbDisk[disk_addr] = disk_data;
  end

  always @(posedge clk) begin
    mem_q <= tbMem[mem_addr];
    if (mem_we) tbMem[mem_addr] = mem_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs come from the transfer rules: word i of a load moves in cycle i+1,
  // word i of a store is read in cycle 2i+1 and written in cycle 2i+2.
  task automatic buildModel(input bit d, input logic [DAW-1:0] db, input logic [MAW-1:0] mb,
                            input int n, input int abIn);
    int cyc, ab, last;
    logic [DW-1:0] s;
    ExpEntry e;
    cyc  = d ? 2 * n : n;
    ab   = (abIn > cyc) ? 0 : abIn;
    last = (ab != 0) ? ab : cyc;
    s    = '0;
    for (int k = 1; k <= last; k++) begin
      e = '{default: 0};
      e.busy = 1'b1;
      if (k != ab) begin
        if (!d) begin
          e.memWe    = 1'b1;
          e.memAddr  = mb + 12'(k - 1);
          e.diskAddr = db + 15'(k - 1);
          e.memData  = refDisk[e.diskAddr];
          refMem[e.memAddr] = e.memData;
          s = s + e.memData;
        end else if (k % 2 == 1) begin
          e.chkRd   = 1'b1;
          e.memAddr = mb + 12'((k - 1) / 2);
        end else begin
          e.diskTr   = 1'b1;
          e.memAddr  = mb + 12'(k / 2 - 1);
          e.diskAddr = db + 15'(k / 2 - 1);
          e.diskData = refMem[e.memAddr];
          refDisk[e.diskAddr] = e.diskData;
          s = s + e.diskData;
        end
      end
      expQ.push_back(e);
    end
    e = '{default: 0};
    e.done   = 1'b1;
    e.chkSum = 1'b1;
    e.sum    = CHK_ON ? s : 16'h0000;
    expQ.push_back(e);
    idleChk = e.sum;
  endtask

  always @(negedge clk) begin
    ExpEntry e;
    if (checkEn) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
      end else begin
        e = '{default: 0};
        e.chkSum = 1'b1;
        e.sum    = idleChk;
      end
      checkOutput("busy", busy, e.busy);
      checkOutput("done", done, e.done);
      checkOutput("memWe", mem_we, e.memWe);
      checkOutput("diskTr", disk_tr, e.diskTr);
      if (e.memWe) begin
        checkOutput("memAddr", mem_addr, e.memAddr);
        checkOutput("memData", mem_data, e.memData);
      end
      if (e.diskTr) begin
        checkOutput("diskAddr", disk_addr, e.diskAddr);
        checkOutput("diskData", disk_data, e.diskData);
      end
      if (e.chkRd) checkOutput("rdAddr", mem_addr, e.memAddr);
      if (e.chkSum) checkOutput("checksum", checksum, e.sum);
    end
  end

  task automatic applyStimulus(input bit d, input logic [DAW-1:0] db, input logic [MAW-1:0] mb,
                               input int n, input int ab, input bit extra);
    int cycles;
    @(negedge clk);
    #1;
    dir = d; disk_base = db; mem_base = mb; len = n[LW-1:0]; start = 1'b1;
    buildModel(d, db, mb, n, ab);
    cycles = expQ.size();
    @(posedge clk);
    for (int k = 1; k <= cycles; k++) begin
      #1;
      dir       = ~d;
      disk_base = 15'($urandom);
      mem_base  = 12'($urandom);
      len       = 15'($urandom_range(0, 30));
      start     = extra && (k == 2);
      abort     = (k == ab) || (extra && k == cycles);
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkImages(input string tag);
    int badMem, badDisk;
    badMem = 0;
    badDisk = 0;
    for (int i = 0; i < 4096; i++) if (tbMem[i] !== refMem[i]) badMem++;
    for (int i = 0; i < 32768; i++) if (tbDisk[i] !== refDisk[i]) badDisk++;
    checkOutput({"memImage_", tag}, badMem, 0);
    checkOutput({"diskImage_", tag}, badDisk, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({"rstBusy_", tag}, busy, 0);
    checkOutput({"rstDone_", tag}, done, 0);
    checkOutput({"rstDiskTr_", tag}, disk_tr, 0);
    checkOutput({"rstMemWe_", tag}, mem_we, 0);
    checkOutput({"rstDiskAddr_", tag}, disk_addr, 0);
    checkOutput({"rstMemAddr_", tag}, mem_addr, 0);
    checkOutput({"rstDiskData_", tag}, disk_data, 0);
    checkOutput({"rstMemData_", tag}, mem_data, 0);
    checkOutput({"rstChecksum_", tag}, checksum, 0);
  endtask

  task automatic setDisk(input logic [DAW-1:0] a, input logic [DW-1:0] v);
    refDisk[a] = v;
    tbDisk[a]  = v;
  endtask

  task automatic setMem(input logic [MAW-1:0] a, input logic [DW-1:0] v);
    refMem[a] = v;
    tbMem[a]  = v;
  endtask

  initial begin
    bit rd, rx;
    int rn, ra;
    for (int i = 0; i < 32768; i++) setDisk(15'(i), 16'($urandom));
    for (int i = 0; i < 4096; i++) setMem(12'(i), 16'($urandom));
    setDisk(15'd2, 16'd333);
    setDisk(15'd5, 16'd50000);

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("start");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    applyStimulus(1'b0, 15'h0000, 12'h100, 10, 0, 1'b0);
    checkImages("boot");
    checkOutput("bootWord2", tbMem[12'h102], 16'd333);
    checkOutput("bootWord5", tbMem[12'h105], 16'd50000);

    setMem(12'h020, 16'h1111);
    setMem(12'h021, 16'h2222);
    setMem(12'h022, 16'h3333);
    applyStimulus(1'b1, 15'h4000, 12'h020, 3, 0, 1'b0);
    checkImages("store");
    checkOutput("storeWord0", tbDisk[15'h4000], 16'h1111);
    checkOutput("storeWord2", tbDisk[15'h4002], 16'h3333);

    setDisk(15'h7FFE, 16'hA000);
    setDisk(15'h7FFF, 16'hA001);
    setDisk(15'h0000, 16'hA002);
    setDisk(15'h0001, 16'hA003);
    applyStimulus(1'b0, 15'h7FFE, 12'hFFE, 4, 0, 1'b1);
    checkImages("wrap");
    checkOutput("wrapMemFFF", tbMem[12'hFFF], 16'hA001);
    checkOutput("wrapMem001", tbMem[12'h001], 16'hA003);

    applyStimulus(1'b0, 15'h0123, 12'h456, 0, 0, 1'b1);
    checkImages("len0");

    for (int i = 0; i < 10; i++) begin
      setDisk(15'h0100 + 15'(i), 16'hB000 + 16'(i));
      setMem(12'h400 + 12'(i), 16'hDEAD);
    end
    applyStimulus(1'b0, 15'h0100, 12'h400, 10, 3, 1'b0);
    checkImages("abort");
    checkOutput("abortWord1", tbMem[12'h401], 16'hB001);
    checkOutput("abortWord2", tbMem[12'h402], 16'hDEAD);

    setDisk(15'h0010, 16'hFFFF);
    setDisk(15'h0011, 16'h0002);
    applyStimulus(1'b0, 15'h0010, 12'h300, 2, 0, 1'b0);
    checkOutput("checksumLit", checksum, CHK_ON ? 16'h0001 : 16'h0000);

    for (int t = 0; t < 30; t++) begin
      rd = 1'($urandom_range(0, 1));
      rn = $urandom_range(0, 12);
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * rn + 1) : 0;
      rx = 1'($urandom_range(0, 1));
      applyStimulus(rd, 15'($urandom), 12'($urandom), rn, ra, rx);
      checkImages("random");
    end

    @(negedge clk);
    #1;
    dir = 1'b1; disk_base = 15'h1234; mem_base = 12'h050; len = 15'd5; start = 1'b1;
    buildModel(1'b1, 15'h1234, 12'h050, 5, 4);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      #1;
      start = 1'b0;
      @(posedge clk);
    end
    #1;
    checkEn = 1'b0;
    expQ.delete();
    rst_n = 1'b0;
    #1;
    checkResetValues("midStore");
    idleChk = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkEn = 1'b1;
    checkImages("reset");

    applyStimulus(1'b0, 15'h2000, 12'h800, 6, 0, 1'b0);
    checkImages("recover");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
